// File: rtl/scanline_buffer.sv
// Double-buffered scanline buffer feeding the palette lookup stage.
// The display bank is streamed out and cleared to bg_colour behind the read.
// The draw bank accepts colour-index writes from the drawing engine.
module scanline_buffer #(
    parameter int         H_RES       = 640,
    parameter int         ADDR_W      = 10,
    parameter logic [7:0] TRANSPARENT = 8'h00
) (
    input  logic              clk_pix,
    input  logic              rst_pix_n,
    input  logic              line_start,
    input  logic              de,
    input  logic [7:0]        bg_colour,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_x,
    input  logic [7:0]        wr_colour,
    input  logic              wr_done,
    output logic [7:0]        colour_pix,
    output logic              de_out,
    output logic              fill_late
);

    // Bank index width. Every address that reaches a bank is below H_RES,
    // so dropping the upper address bits loses nothing.
    localparam int                IDX_W   = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam logic [ADDR_W-1:0] LAST_X  = ADDR_W'(H_RES - 1);
    localparam logic [ADDR_W:0]   H_RES_X = (ADDR_W + 1)'(H_RES);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_x_q, clr_x_d;
    logic              bank_sel_q, bank_sel_d;
    logic [ADDR_W-1:0] rd_x_q, rd_x_d;
    logic              done_seen_q, done_seen_d;
    logic [7:0]        colour_pix_q, colour_pix_d;
    logic              de_out_q, de_out_d;
    logic              fill_late_q, fill_late_d;

    logic [7:0] bank0_q [0:H_RES-1];
    logic [7:0] bank1_q [0:H_RES-1];

    logic              rd_bank;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;

    logic              we0, we1;
    logic [ADDR_W-1:0] wa0, wa1;
    logic [7:0]        wd0, wd1;
    logic              draw_we;

    // Display read select: a coincident line_start redirects the read to pixel 0 of the incoming bank.
    always_comb begin
        rd_bank = bank_sel_q;
        rd_addr = rd_x_q;
        if (line_start) begin
            rd_bank = ~bank_sel_q;
            rd_addr = '0;
        end
        rd_data = rd_bank ? bank1_q[rd_addr[IDX_W-1:0]] : bank0_q[rd_addr[IDX_W-1:0]];
    end

    // Next-state, output and bank write-port selection for the INIT sweep and RUN operation.
    always_comb begin
        state_d      = state_q;
        clr_x_d      = clr_x_q;
        bank_sel_d   = bank_sel_q;
        rd_x_d       = rd_x_q;
        done_seen_d  = done_seen_q;
        colour_pix_d = 8'h00;
        de_out_d     = 1'b0;
        fill_late_d  = 1'b0;
        wr_ready     = 1'b0;
        draw_we      = 1'b0;
        we0          = 1'b0;
        we1          = 1'b0;
        wa0          = '0;
        wa1          = '0;
        wd0          = bg_colour;
        wd1          = bg_colour;

        case (state_q)
            ST_INIT: begin
                we0     = 1'b1;
                we1     = 1'b1;
                wa0     = clr_x_q;
                wa1     = clr_x_q;
                clr_x_d = clr_x_q + 1'b1;
                if (clr_x_q == LAST_X) begin
                    state_d = ST_RUN;
                    clr_x_d = '0;
                end
            end

            ST_RUN: begin
                wr_ready = ~done_seen_q & ~line_start;

                if (line_start) begin
                    bank_sel_d  = ~bank_sel_q;
                    rd_x_d      = '0;
                    fill_late_d = ~done_seen_q;
                    done_seen_d = 1'b0;
                end else if (wr_done) begin
                    done_seen_d = 1'b1;
                end

                if (de) begin
                    colour_pix_d = rd_data;
                    de_out_d     = 1'b1;
                    rd_x_d       = (rd_addr == LAST_X) ? LAST_X : rd_addr + 1'b1;
                    if (rd_bank) begin
                        we1 = 1'b1;
                        wa1 = rd_addr;
                    end else begin
                        we0 = 1'b1;
                        wa0 = rd_addr;
                    end
                end

                // Transparent and off-screen writes complete the handshake but store nothing.
                draw_we = wr_valid & wr_ready & (wr_colour != TRANSPARENT) &
                          ({1'b0, wr_x} < H_RES_X);
                if (draw_we) begin
                    if (bank_sel_q) begin
                        we0 = 1'b1;
                        wa0 = wr_x;
                        wd0 = wr_colour;
                    end else begin
                        we1 = 1'b1;
                        wa1 = wr_x;
                        wd1 = wr_colour;
                    end
                end
            end

            default: state_d = ST_INIT;
        endcase
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            state_q      <= ST_INIT;
            clr_x_q      <= '0;
            bank_sel_q   <= 1'b0;
            rd_x_q       <= '0;
            done_seen_q  <= 1'b0;
            colour_pix_q <= 8'h00;
            de_out_q     <= 1'b0;
            fill_late_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_x_q      <= clr_x_d;
            bank_sel_q   <= bank_sel_d;
            rd_x_q       <= rd_x_d;
            done_seen_q  <= done_seen_d;
            colour_pix_q <= colour_pix_d;
            de_out_q     <= de_out_d;
            fill_late_q  <= fill_late_d;
        end
    end

    // Bank storage: one write port per bank, no reset (the INIT sweep clears it).
    always_ff @(posedge clk_pix) begin
        if (we0) begin
            bank0_q[wa0[IDX_W-1:0]] <= wd0;
        end
        if (we1) begin
            bank1_q[wa1[IDX_W-1:0]] <= wd1;
        end
    end

    assign colour_pix = colour_pix_q;
    assign de_out     = de_out_q;
    assign fill_late  = fill_late_q;

endmodule

// File: tb/tb_scanline_buffer.sv
// Testbench for scanline_buffer: directed scenarios plus random traffic,
// every cycle compared against a line-level behavioural model.
module tb_scanline_buffer;

    localparam int H  = 16;
    // One address bit more than the line needs, so off-screen x values can be driven.
    localparam int AW = 5;

    logic clk_pix = 1'b0;
    always #5 clk_pix = ~clk_pix;

    logic          rst_pix_n  = 1'b0;
    logic          line_start = 1'b0;
    logic          de         = 1'b0;
    logic [7:0]    bg_colour  = 8'h11;
    logic          wr_valid   = 1'b0;
    logic [AW-1:0] wr_x       = '0;
    logic [7:0]    wr_colour  = 8'h00;
    logic          wr_done    = 1'b0;
    logic          wr_ready;
    logic [7:0]    colour_pix;
    logic          de_out;
    logic          fill_late;

    scanline_buffer #(
        .H_RES      (H),
        .ADDR_W     (AW),
        .TRANSPARENT(8'h00)
    ) dut (
        .clk_pix   (clk_pix),
        .rst_pix_n (rst_pix_n),
        .line_start(line_start),
        .de        (de),
        .bg_colour (bg_colour),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_x      (wr_x),
        .wr_colour (wr_colour),
        .wr_done   (wr_done),
        .colour_pix(colour_pix),
        .de_out    (de_out),
        .fill_late (fill_late)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: two line images, which one is on screen, read position, draw status.
    logic [7:0] m_bank [2][H];
    bit         m_known     = 1'b0;
    int         m_init_left = 0;
    int         m_sel       = 0;
    int         m_rdx       = 0;
    bit         m_done      = 1'b0;
    logic [7:0] m_colour    = 8'h00;
    logic       m_de_out    = 1'b0;
    logic       m_fill      = 1'b0;

    logic       obs_rdy;
    logic [7:0] obs_col;
    logic       obs_de;
    logic       obs_fill;
    logic [7:0] line_buf [H];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rn, input logic ls, input logic d, input logic wv,
                              input logic [AW-1:0] wx, input logic [7:0] wc, input logic wd);
        bit rdy;
        if (!rn) begin
            m_known = 1'b1; m_init_left = H; m_sel = 0; m_rdx = 0; m_done = 1'b0;
            m_colour = 8'h00; m_de_out = 1'b0; m_fill = 1'b0;
        end else if (m_init_left > 0) begin
            m_bank[0][H - m_init_left] = bg_colour;
            m_bank[1][H - m_init_left] = bg_colour;
            m_init_left--;
            m_colour = 8'h00; m_de_out = 1'b0; m_fill = 1'b0;
        end else begin
            rdy = !m_done && !ls;
            if (rdy && wv && wc != 8'h00 && int'(wx) < H)
                m_bank[1 - m_sel][int'(wx)] = wc;
            m_fill = ls && !m_done;
            if (ls) begin
                m_sel = 1 - m_sel; m_rdx = 0; m_done = 1'b0;
            end else if (wd) begin
                m_done = 1'b1;
            end
            if (d) begin
                m_colour = m_bank[m_sel][m_rdx];
                m_bank[m_sel][m_rdx] = bg_colour;
                if (m_rdx < H - 1) m_rdx++;
                m_de_out = 1'b1;
            end else begin
                m_colour = 8'h00; m_de_out = 1'b0;
            end
        end
    endtask

    // One clock: drive inputs, check wr_ready before the edge, check registered outputs after it.
    task automatic step(input logic rn, input logic ls, input logic d, input logic wv,
                        input logic [AW-1:0] wx, input logic [7:0] wc, input logic wd);
        rst_pix_n = rn; line_start = ls; de = d; wr_valid = wv;
        wr_x = wx; wr_colour = wc; wr_done = wd;
        #1;
        obs_rdy = wr_ready;
        if (m_known)
            chk("wr_ready", 32'(wr_ready), 32'((m_init_left == 0) && !m_done && !ls));
        @(posedge clk_pix);
        model_edge(rn, ls, d, wv, wx, wc, wd);
        #1;
        obs_col = colour_pix; obs_de = de_out; obs_fill = fill_late;
        chk("colour_pix", 32'(colour_pix), 32'(m_colour));
        chk("de_out", 32'(de_out), 32'(m_de_out));
        chk("fill_late", 32'(fill_late), 32'(m_fill));
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, 8'h00, 1'b0);
    endtask

    task automatic wr(input logic [AW-1:0] x, input logic [7:0] c);
        step(1'b1, 1'b0, 1'b0, 1'b1, x, c, 1'b0);
    endtask

    task automatic read_pixels();
        for (int i = 0; i < H; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, '0, 8'h00, 1'b0);
            line_buf[i] = obs_col;
            chk("de_out_align", 32'(obs_de), 32'd1);
        end
        idle();
        chk("de_out_low", 32'(obs_de), 32'd0);
    endtask

    task automatic show_line();
        step(1'b1, 1'b1, 1'b0, 1'b0, '0, 8'h00, 1'b0);
        read_pixels();
    endtask

    initial begin
        int zeros;

        // Reset and init sweep
        bg_colour = 8'h11;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0, 8'h00, 1'b0);
        zeros = 0;
        for (int i = 0; i < 40; i++) begin
            idle();
            if (obs_rdy === 1'b1) break;
            zeros++;
        end
        chk("init_len", 32'(zeros), 32'd16);
        show_line();
        for (int i = 0; i < H; i++) chk("init_bg", 32'(line_buf[i]), 32'h11);

        // Write, swap, display, then the cleared banks
        for (int i = 0; i < H; i++) wr(AW'(i), 8'h20 + 8'(i));
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, 8'h00, 1'b1);
        show_line();
        for (int i = 0; i < H; i++) chk("line_data", 32'(line_buf[i]), 32'(8'h20 + 8'(i)));
        show_line();
        for (int i = 0; i < H; i++) chk("other_bank_bg", 32'(line_buf[i]), 32'h11);
        show_line();
        for (int i = 0; i < H; i++) chk("cleared_bg", 32'(line_buf[i]), 32'h11);

        // Transparent and off-screen writes
        wr(AW'(3), 8'h40);  chk("hs_opaque", 32'(obs_rdy), 32'd1);
        wr(AW'(3), 8'h00);  chk("hs_transp", 32'(obs_rdy), 32'd1);
        wr(AW'(20), 8'h55); chk("hs_offscr", 32'(obs_rdy), 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, 8'h00, 1'b1);
        show_line();
        for (int i = 0; i < H; i++)
            chk("transp_line", 32'(line_buf[i]), (i == 3) ? 32'h40 : 32'h11);

        // Back-pressure after wr_done mid-line
        step(1'b1, 1'b1, 1'b0, 1'b0, '0, 8'h00, 1'b0);
        for (int i = 0; i < H; i++) begin
            if (i == 0)      step(1'b1, 1'b0, 1'b1, 1'b1, AW'(2), 8'h33, 1'b0);
            else if (i == 5) step(1'b1, 1'b0, 1'b1, 1'b0, '0, 8'h00, 1'b1);
            else if (i > 5) begin
                step(1'b1, 1'b0, 1'b1, 1'b1, AW'(i), 8'h77, 1'b0);
                chk("bp_ready", 32'(obs_rdy), 32'd0);
            end else         step(1'b1, 1'b0, 1'b1, 1'b0, '0, 8'h00, 1'b0);
        end
        step(1'b1, 1'b1, 1'b0, 1'b1, AW'(0), 8'h77, 1'b0);
        chk("swap_ready", 32'(obs_rdy), 32'd0);
        read_pixels();
        for (int i = 0; i < H; i++)
            chk("bp_line", 32'(line_buf[i]), (i == 2) ? 32'h33 : 32'h11);

        // Late fill
        idle();
        step(1'b1, 1'b1, 1'b0, 1'b0, '0, 8'h00, 1'b0);
        chk("fill_late_set", 32'(obs_fill), 32'd1);
        idle();
        chk("fill_late_pulse", 32'(obs_fill), 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, 8'h00, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, '0, 8'h00, 1'b0);
        chk("fill_on_time", 32'(obs_fill), 32'd0);

        // Reset during a line at rd_x=7
        step(1'b1, 1'b1, 1'b0, 1'b0, '0, 8'h00, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b1, 1'b0, '0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, '0, 8'h00, 1'b0);
        chk("rst_colour", 32'(obs_col), 32'd0);
        chk("rst_de_out", 32'(obs_de), 32'd0);
        idle();
        chk("rst_init_ready", 32'(obs_rdy), 32'd0);
        for (int i = 0; i < H + 2; i++) idle();

        // line_start coincident with de
        wr(AW'(0), 8'h5A);
        wr(AW'(1), 8'h5B);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, 8'h00, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, '0, 8'h00, 1'b0);
        chk("collide_px0", 32'(obs_col), 32'h5A);
        step(1'b1, 1'b0, 1'b1, 1'b0, '0, 8'h00, 1'b0);
        chk("collide_px1", 32'(obs_col), 32'h5B);
        for (int i = 0; i < H; i++) step(1'b1, 1'b0, 1'b1, 1'b0, '0, 8'h00, 1'b0);

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            logic rn, ls, d, wv, wd;
            logic [7:0] c;
            rn = ($urandom_range(0, 199) != 0);
            ls = ($urandom_range(0, 19) == 0);
            d  = ($urandom_range(0, 3) != 0);
            wv = $urandom_range(0, 1) == 1;
            wd = !ls && ($urandom_range(0, 29) == 0);
            c  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            bg_colour = 8'($urandom_range(0, 255));
            step(rn, ls, d, wv, AW'($urandom_range(0, 31)), c, wd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
